// File: rtl/conv_pkg.sv
// Shared types and output-geometry helpers for the sliding-window front end.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package conv_pkg;

    // Pixel width used when no override is given; RTL modules carry their own DATA_W.
    localparam int DEF_DATA_W = 8;

    typedef logic signed [DEF_DATA_W-1:0] pix_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Number of window positions along one axis for a valid (unpadded) convolution.
    function automatic int out_dim(input int img, input int k, input int stride);
        return (img - k) / stride + 1;
    endfunction

    // Geometry of the default 28x28, 3x3, stride-1 configuration.
    localparam int DEF_OUT_W = out_dim(28, 3, 1);
    localparam int DEF_OUT_H = out_dim(28, 3, 1);

endpackage

// File: rtl/conv_line_buf.sv
// Single-lane line buffer: shift FIFO of DEPTH entries, advancing only on ena.
// Latency: dout is the sample written DEPTH enabled cycles earlier.
// Backpressure: none; ena stalls the whole lane.
// Ports: clk; ena (shift enable); din (sample in); dout (oldest sample).
module conv_line_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 28
) (
    input  logic                     clk,
    input  logic                     ena,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] dout
);

    // Contents are never observed before a full line has been shifted in,
    // so the storage needs no reset.
    logic signed [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ena) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator with K-1 line buffers and configurable stride.
// Latency: one cycle from the accepting input beat to win_valid.
// Backpressure: none; the consumer must take one window per cycle.
// Ports: clk/rst_n; raster input (frame/line/end markers, ena_in, pix_in);
//        window output (win_valid, win_out, regenerated markers); sticky err_line/err_short.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int STRIDE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start_in,
    input  logic                     line_start_in,
    input  logic                     frame_end_in,
    input  logic                     ena_in,
    input  logic signed [DATA_W-1:0] pix_in,
    output logic                     win_valid,
    output logic [K*K*DATA_W-1:0]    win_out,
    output logic                     frame_start_out,
    output logic                     line_start_out,
    output logic                     frame_end_out,
    output logic                     err_line,
    output logic                     err_short
);

    localparam int OUT_W    = out_dim(IMG_W, K, STRIDE);
    localparam int OUT_H    = out_dim(IMG_H, K, STRIDE);
    // Input coordinates of the final window's bottom-right pixel.
    localparam int LAST_COL = (K - 1) + (OUT_W - 1) * STRIDE;
    localparam int LAST_ROW = (K - 1) + (OUT_H - 1) * STRIDE;
    localparam int NPIX     = IMG_W * IMG_H;
    localparam int COL_W    = $clog2(IMG_W + 1);
    localparam int ROW_W    = $clog2(IMG_H + 1);
    localparam int CNT_W    = $clog2(NPIX + 1);

    if (IMG_W < K) begin : g_bad_w
        $error("conv_window_gen: IMG_W must be >= K");
    end
    if (IMG_H < K) begin : g_bad_h
        $error("conv_window_gen: IMG_H must be >= K");
    end
    if (STRIDE != 1 && STRIDE != 2) begin : g_bad_stride
        $error("conv_window_gen: STRIDE must be 1 or 2");
    end
    if (K < 2 || K > 7) begin : g_bad_k
        $error("conv_window_gen: K must be in 2..7");
    end

    state_t           state, state_nxt;
    logic [COL_W-1:0] col, pos_col;   // col = pixels stored in current line
    logic [ROW_W-1:0] row, pos_row;   // row saturates at IMG_H on surplus lines
    logic [CNT_W-1:0] cnt, cnt_nxt;   // accepted pixels this frame, saturating
    logic             start, run, accept, line_err, short_err, emit;
    int               ri, ci;

    logic signed [DATA_W-1:0] win_sr  [K][K];
    logic signed [DATA_W-1:0] win_nxt [K][K];
    logic signed [DATA_W-1:0] lb_in   [K-1];
    logic signed [DATA_W-1:0] lb_out  [K-1];
    logic [K*K*DATA_W-1:0]    win_flat;

    // Buffers are chained: lb_out[i] is the pixel i+1 lines above pix_in.
    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        if (i == 0) begin : g_head
            assign lb_in[i] = pix_in;
        end else begin : g_tail
            assign lb_in[i] = lb_out[i-1];
        end
        conv_line_buf #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W)
        ) u_lb (
            .clk  (clk),
            .ena  (accept),
            .din  (lb_in[i]),
            .dout (lb_out[i])
        );
    end

    // Beat classification, pixel position and error detection.
    always_comb begin
        start     = ena_in && frame_start_in;
        run       = ena_in && !frame_start_in && (state == ACTIVE);
        accept    = 1'b0;
        pos_col   = col;
        pos_row   = row;
        line_err  = 1'b0;
        if (start) begin
            // Any frame_start beat (re)starts the frame at (0,0).
            accept  = 1'b1;
            pos_col = '0;
            pos_row = '0;
        end else if (run) begin
            if (line_start_in) begin
                accept   = 1'b1;
                pos_col  = '0;
                pos_row  = (row == ROW_W'(IMG_H)) ? row : row + ROW_W'(1);
                line_err = (col != COL_W'(IMG_W));
            end else if (col == COL_W'(IMG_W)) begin
                line_err = 1'b1;   // overlong line: pixel dropped
            end else begin
                accept = 1'b1;
            end
        end

        cnt_nxt = cnt;
        if (start) begin
            cnt_nxt = CNT_W'(1);
        end else if (accept && (cnt != CNT_W'(NPIX))) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
        short_err = (start || run) && frame_end_in && (cnt_nxt != CNT_W'(NPIX));

        state_nxt = state;
        if ((start || run) && frame_end_in) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = ACTIVE;
        end

        ri   = int'(pos_row);
        ci   = int'(pos_col);
        emit = accept
            && (ri >= K - 1) && (ri < IMG_H)
            && (ci >= K - 1)
            && (((ri - (K - 1)) % STRIDE) == 0)
            && (((ci - (K - 1)) % STRIDE) == 0);
    end

    // Window shifts left one column; the new right column is the vertical
    // slice {oldest line .. newest line, pix_in}.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_nxt[r][c] = win_sr[r][c+1];
            end
        end
        for (int r = 0; r < K - 1; r++) begin
            win_nxt[r][K-1] = lb_out[K-2-r];
        end
        win_nxt[K-1][K-1] = pix_in;

        win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_flat[(r*K+c)*DATA_W +: DATA_W] = win_nxt[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            win_sr <= win_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            col             <= '0;
            row             <= '0;
            cnt             <= '0;
            win_valid       <= 1'b0;
            win_out         <= '0;
            frame_start_out <= 1'b0;
            line_start_out  <= 1'b0;
            frame_end_out   <= 1'b0;
            err_line        <= 1'b0;
            err_short       <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                row <= pos_row;
                col <= pos_col + COL_W'(1);
            end
            win_valid       <= emit;
            frame_start_out <= emit && (ri == K - 1) && (ci == K - 1);
            line_start_out  <= emit && (ci == K - 1);
            frame_end_out   <= emit && (ri == LAST_ROW) && (ci == LAST_COL);
            if (emit) begin
                win_out <= win_flat;
            end
            if (line_err) begin
                err_line <= 1'b1;
            end
            if (short_err) begin
                err_short <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench: 5x5 frames into a stride-1 and a stride-2 instance driven in parallel.
// Latency: n/a.
// Backpressure: n/a.
module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int KK = 3;
    localparam int WB = KK * KK * DW;

    typedef struct packed {
        logic [WB-1:0] win;
        logic          fs;
        logic          ls;
        logic          fe;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start_in = 1'b0;
    logic line_start_in = 1'b0;
    logic frame_end_in = 1'b0;
    logic ena_in = 1'b0;
    pix_t pix_in = '0;

    logic          v1, fs1, ls1, fe1, el1, es1;
    logic          v2, fs2, ls2, fe2, el2, es2;
    logic [WB-1:0] w1, w2;

    int   checks = 0;
    int   failures = 0;
    bit   gaps = 1'b0;
    logic last_beat = 1'b0;
    rec_t obs1[$], obs2[$], exp1[$], exp2[$];

    conv_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(KK), .STRIDE(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n),
        .frame_start_in(frame_start_in), .line_start_in(line_start_in),
        .frame_end_in(frame_end_in), .ena_in(ena_in), .pix_in(pix_in),
        .win_valid(v1), .win_out(w1),
        .frame_start_out(fs1), .line_start_out(ls1), .frame_end_out(fe1),
        .err_line(el1), .err_short(es1)
    );

    conv_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(KK), .STRIDE(2)) dut_s2 (
        .clk(clk), .rst_n(rst_n),
        .frame_start_in(frame_start_in), .line_start_in(line_start_in),
        .frame_end_in(frame_end_in), .ena_in(ena_in), .pix_in(pix_in),
        .win_valid(v2), .win_out(w2),
        .frame_start_out(fs2), .line_start_out(ls2), .frame_end_out(fe2),
        .err_line(el2), .err_short(es2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) last_beat <= ena_in;

    // Capture windows; every window must follow an input beat and markers need win_valid.
    always @(negedge clk) begin
        if (v1) begin
            check_eq("s1_valid_after_beat", 128'(last_beat), 128'(1));
            obs1.push_back('{win: w1, fs: fs1, ls: ls1, fe: fe1});
        end else begin
            check_eq("s1_markers_idle", 128'({fs1, ls1, fe1}), 128'(0));
        end
        if (v2) begin
            check_eq("s2_valid_after_beat", 128'(last_beat), 128'(1));
            obs2.push_back('{win: w2, fs: fs2, ls: ls2, fe: fe2});
        end else begin
            check_eq("s2_markers_idle", 128'({fs2, ls2, fe2}), 128'(0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic beat(input bit fs, input bit ls, input bit fe, input int pix);
        int n;
        n = 0;
        // Idle cycles carry random markers, which must be ignored without ena_in.
        while (gaps && ($urandom_range(0, 1) == 1) && (n < 6)) begin
            frame_start_in = 1'($urandom_range(0, 1));
            line_start_in  = 1'($urandom_range(0, 1));
            frame_end_in   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        frame_start_in = fs;
        line_start_in  = ls;
        frame_end_in   = fe;
        pix_in         = DW'(pix);
        ena_in         = 1'b1;
        @(posedge clk); #1;
        ena_in         = 1'b0;
        frame_start_in = 1'b0;
        line_start_in  = 1'b0;
        frame_end_in   = 1'b0;
    endtask

    task automatic send_rows(input int base, input int nrows, input bit with_fe);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < W; c++) begin
                beat(r == 0 && c == 0, c == 0, with_fe && r == nrows - 1 && c == W - 1,
                     base + r * W + c);
            end
        end
    endtask

    // Expected windows for the first nrows lines of a frame with pix = base + r*W + c.
    task automatic push_exp(input int base, input int s, input int nrows, input int which);
        int   oh, ow;
        rec_t rec;
        oh = (H - KK) / s + 1;
        ow = (W - KK) / s + 1;
        for (int orow = 0; orow < oh; orow++) begin
            if (orow * s + KK - 1 < nrows) begin
                for (int ocol = 0; ocol < ow; ocol++) begin
                    rec = '0;
                    for (int r = 0; r < KK; r++) begin
                        for (int c = 0; c < KK; c++) begin
                            rec.win[(r*KK+c)*DW +: DW] = DW'(base + (orow*s + r) * W + ocol*s + c);
                        end
                    end
                    rec.fs = (orow == 0 && ocol == 0);
                    rec.ls = (ocol == 0);
                    rec.fe = (orow == oh - 1 && ocol == ow - 1);
                    if (which == 1) exp1.push_back(rec);
                    else exp2.push_back(rec);
                end
            end
        end
    endtask

    task automatic settle();
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_q();
        obs1.delete(); obs2.delete(); exp1.delete(); exp2.delete();
    endtask

    task automatic compare(input string name);
        check_eq({name, "_s1_count"}, 128'(obs1.size()), 128'(exp1.size()));
        for (int i = 0; i < exp1.size() && i < obs1.size(); i++)
            check_eq($sformatf("%s_s1_win%0d", name, i), 128'(obs1[i]), 128'(exp1[i]));
        check_eq({name, "_s2_count"}, 128'(obs2.size()), 128'(exp2.size()));
        for (int i = 0; i < exp2.size() && i < obs2.size(); i++)
            check_eq($sformatf("%s_s2_win%0d", name, i), 128'(obs2[i]), 128'(exp2[i]));
        clear_q();
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_s1"}, 128'({v1, w1, fs1, ls1, fe1, el1, es1}), 128'(0));
        check_eq({tag, "_s2"}, 128'({v2, w2, fs2, ls2, fe2, el2, es2}), 128'(0));
    endtask

    // Hand-computed values for the base-0 5x5 frame.
    task automatic hand_checks(input string tag);
        int tl [4];
        bit lsx [4];
        tl  = '{0, 2, 10, 12};
        lsx = '{1'b1, 1'b0, 1'b1, 1'b0};
        if (obs1.size() == 9) begin
            check_eq({tag, "_first_win"}, 128'(obs1[0].win), 128'(72'h0C0B0A_070605_020100));
            check_eq({tag, "_first_fs_ls"}, 128'({obs1[0].fs, obs1[0].ls}), 128'(2'b11));
            check_eq({tag, "_last_win"}, 128'(obs1[8].win), 128'(72'h181716_131211_0E0D0C));
            check_eq({tag, "_last_fe"}, 128'(obs1[8].fe), 128'(1));
        end
        if (obs2.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("%s_s2_tl%0d", tag, i), 128'(obs2[i].win[7:0]), 128'(tl[i]));
                check_eq($sformatf("%s_s2_ls%0d", tag, i), 128'(obs2[i].ls), 128'(lsx[i]));
            end
            check_eq({tag, "_s2_fe"}, 128'(obs2[3].fe), 128'(1));
        end
        check_eq({tag, "_errs"}, 128'({el1, es1, el2, es2}), 128'(0));
    endtask

    initial begin
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean frame, continuous beats.
        gaps = 1'b0;
        send_rows(0, H, 1'b1);
        push_exp(0, 1, H, 1); push_exp(0, 2, H, 2);
        settle();
        hand_checks("s1");
        compare("s1");

        // Same frame with gaps on ena_in.
        gaps = 1'b1;
        send_rows(0, H, 1'b1);
        push_exp(0, 1, H, 1); push_exp(0, 2, H, 2);
        settle();
        hand_checks("gap");
        compare("gap");
        gaps = 1'b0;

        // Frame A aborted at (3,1) by frame B.
        send_rows(0, 3, 1'b0);
        beat(1'b0, 1'b1, 1'b0, 15);
        send_rows(100, H, 1'b1);
        push_exp(0, 1, 3, 1); push_exp(0, 2, 3, 2);
        push_exp(100, 1, H, 1); push_exp(100, 2, H, 2);
        settle();
        if (obs1.size() > 3)
            check_eq("restart_b_first_tl", 128'(obs1[3].win[7:0]), 128'(100));
        check_eq("restart_errs", 128'({el1, es1, el2, es2}), 128'(0));
        compare("restart");

        // Short line 2, then restart with a clean frame.
        send_rows(0, 2, 1'b0);
        for (int c = 0; c < 4; c++) beat(1'b0, c == 0, 1'b0, 10 + c);
        for (int c = 0; c < W; c++) beat(1'b0, c == 0, 1'b0, 15 + c);
        settle();
        clear_q();
        check_eq("shortline_err_line", 128'({el1, el2}), 128'(2'b11));
        check_eq("shortline_err_short", 128'({es1, es2}), 128'(0));
        send_rows(0, H, 1'b1);
        push_exp(0, 1, H, 1); push_exp(0, 2, H, 2);
        settle();
        check_eq("clean_err_line_sticky", 128'({el1, el2}), 128'(2'b11));
        check_eq("clean_err_short", 128'({es1, es2}), 128'(0));
        compare("clean");

        // Frame ends after 20 pixels.
        send_rows(50, 4, 1'b1);
        push_exp(50, 1, 4, 1); push_exp(50, 2, 4, 2);
        settle();
        check_eq("short_err_short", 128'({es1, es2}), 128'(2'b11));
        compare("short");

        // Beats in IDLE without frame_start_in.
        for (int i = 0; i < 10; i++) beat(1'b0, (i % W) == 0, 1'b0, i);
        settle();
        compare("idle");

        // Async reset mid-frame.
        send_rows(0, 3, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        clear_q();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_rows(0, H, 1'b1);
        push_exp(0, 1, H, 1); push_exp(0, 2, H, 2);
        settle();
        hand_checks("post_reset");
        compare("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
